// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA pipeline widths, ball sprite constants and stream bundle type
package vga_pkg;

  localparam int          HCNT_W      = 11;
  localparam int          RGB_W       = 12;
  localparam int          PIX_W       = 4;
  localparam int          BALL_SIZE   = 64;
  localparam int          BALL_ADDR_W = 12;
  localparam logic [3:0]  TRANSP_IDX  = 4'h0;
  localparam logic [11:0] BBOX_COLOUR = 12'hF00;

  // Timing plus colour as it travels down the overlay pipeline.
  typedef struct packed {
    logic [HCNT_W-1:0] hcount;
    logic [HCNT_W-1:0] vcount;
    logic              hsync;
    logic              vsync;
    logic              hblnk;
    logic              vblnk;
    logic [RGB_W-1:0]  rgb;
  } vga_bus_t;

endpackage

// File: rtl/ball_palette.sv
// rtl/ball_palette.sv - fixed 16-entry ball palette, 4-bit index to 12-bit rgb
module ball_palette
  import vga_pkg::*;
(
  input  logic [PIX_W-1:0] idx,
  output logic [RGB_W-1:0] rgb
);

  // Entry 0 is the transparent index and is never displayed.
  always_comb begin
    rgb = 12'h000;
    case (idx)
      4'h0: rgb = 12'h000;
      4'h1: rgb = 12'hFFF;
      4'h2: rgb = 12'hF00;
      4'h3: rgb = 12'h0F0;
      4'h4: rgb = 12'h00F;
      4'h5: rgb = 12'hFF0;
      4'h6: rgb = 12'hF0F;
      4'h7: rgb = 12'h0FF;
      4'h8: rgb = 12'h888;
      4'h9: rgb = 12'hCCC;
      4'hA: rgb = 12'h840;
      4'hB: rgb = 12'hF80;
      4'hC: rgb = 12'h08F;
      4'hD: rgb = 12'h4A4;
      4'hE: rgb = 12'hA4A;
      4'hF: rgb = 12'h222;
      default: rgb = 12'h000;
    endcase
  end

endmodule

// File: rtl/draw_ball.sv
// rtl/draw_ball.sv - 3-stage ball sprite overlay; DRAW_BALL_BBOX_EN adds a debug bounding box
module draw_ball #(
  parameter int         BALL_SIZE  = vga_pkg::BALL_SIZE,
  parameter logic [3:0] TRANSP_IDX = vga_pkg::TRANSP_IDX
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [vga_pkg::HCNT_W-1:0]    hcount_in,
  input  logic [vga_pkg::HCNT_W-1:0]    vcount_in,
  input  logic                          hsync_in,
  input  logic                          vsync_in,
  input  logic                          hblnk_in,
  input  logic                          vblnk_in,
  input  logic [vga_pkg::RGB_W-1:0]     rgb_in,
  input  logic [vga_pkg::HCNT_W-1:0]    xpos,
  input  logic [vga_pkg::HCNT_W-1:0]    ypos,
  output logic [vga_pkg::BALL_ADDR_W-1:0] rom_addr,
  input  logic [vga_pkg::PIX_W-1:0]     rom_pixel,
  output logic [vga_pkg::HCNT_W-1:0]    hcount_out,
  output logic [vga_pkg::HCNT_W-1:0]    vcount_out,
  output logic                          hsync_out,
  output logic                          vsync_out,
  output logic                          hblnk_out,
  output logic                          vblnk_out,
  output logic [vga_pkg::RGB_W-1:0]     rgb_out
);

  import vga_pkg::*;

  localparam int OFS_W = $clog2(BALL_SIZE);

  logic              vblnk_prev;
  logic [HCNT_W-1:0] x_lat;
  logic [HCNT_W-1:0] y_lat;

  // Position only moves at the start of vertical blank, so a frame never tears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vblnk_prev <= 1'b0;
      x_lat      <= '0;
      y_lat      <= '0;
    end else begin
      vblnk_prev <= vblnk_in;
      if (vblnk_in && !vblnk_prev) begin
        x_lat <= xpos;
        y_lat <= ypos;
      end
    end
  end

  // Stage 1 combinational: box test on 12-bit sums so a ball near the right edge clips.
  logic [HCNT_W:0]  h_ext, v_ext, x_ext, y_ext;
  logic [OFS_W-1:0] dx, dy;
  logic             in_box_c;
  logic             blank_c;
  logic [BALL_ADDR_W-1:0] addr_c;
  vga_bus_t         bus_in;

  always_comb begin
    h_ext    = {1'b0, hcount_in};
    v_ext    = {1'b0, vcount_in};
    x_ext    = {1'b0, x_lat};
    y_ext    = {1'b0, y_lat};
    dx       = hcount_in[OFS_W-1:0] - x_lat[OFS_W-1:0];
    dy       = vcount_in[OFS_W-1:0] - y_lat[OFS_W-1:0];
    in_box_c = (h_ext >= x_ext) && (h_ext < x_ext + (HCNT_W+1)'(BALL_SIZE)) &&
               (v_ext >= y_ext) && (v_ext < y_ext + (HCNT_W+1)'(BALL_SIZE));
    blank_c  = hblnk_in | vblnk_in;
    addr_c   = in_box_c ? BALL_ADDR_W'({dy, dx}) : '0;
    bus_in   = '{hcount: hcount_in, vcount: vcount_in, hsync: hsync_in, vsync: vsync_in,
                 hblnk: hblnk_in, vblnk: vblnk_in, rgb: rgb_in};
  end

`ifdef DRAW_BALL_BBOX_EN
  logic border_c, border_d1, border_d2;
  always_comb begin
    border_c = in_box_c &&
               (dx == '0 || dx == '1 || dy == '0 || dy == '1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      border_d1 <= 1'b0;
      border_d2 <= 1'b0;
    end else begin
      border_d1 <= border_c;
      border_d2 <= border_d1;
    end
  end
`endif

  vga_bus_t bus_d1, bus_d2;
  logic     in_box_d1, in_box_d2;
  logic     blank_d1, blank_d2;

  // Stages 1 and 2: rom_addr leaves with stage 1, ROM data returns alongside stage 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr  <= '0;
      bus_d1    <= '0;
      bus_d2    <= '0;
      in_box_d1 <= 1'b0;
      in_box_d2 <= 1'b0;
      blank_d1  <= 1'b0;
      blank_d2  <= 1'b0;
    end else begin
      rom_addr  <= addr_c;
      bus_d1    <= bus_in;
      in_box_d1 <= in_box_c;
      blank_d1  <= blank_c;
      bus_d2    <= bus_d1;
      in_box_d2 <= in_box_d1;
      blank_d2  <= blank_d1;
    end
  end

  logic [RGB_W-1:0] pal_rgb;
  logic [RGB_W-1:0] rgb_next;

  ball_palette u_palette (
    .idx (rom_pixel),
    .rgb (pal_rgb)
  );

  always_comb begin
    rgb_next = bus_d2.rgb;
    if (in_box_d2 && !blank_d2 && rom_pixel != TRANSP_IDX)
      rgb_next = pal_rgb;
`ifdef DRAW_BALL_BBOX_EN
    if (border_d2 && !blank_d2)
      rgb_next = BBOX_COLOUR;
`endif
  end

  // Stage 3: every timing signal gets the same three-clock delay as rgb.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= '0;
    end else begin
      hcount_out <= bus_d2.hcount;
      vcount_out <= bus_d2.vcount;
      hsync_out  <= bus_d2.hsync;
      vsync_out  <= bus_d2.vsync;
      hblnk_out  <= bus_d2.hblnk;
      vblnk_out  <= bus_d2.vblnk;
      rgb_out    <= rgb_next;
    end
  end

endmodule

// File: tb/tb_draw_ball.sv
// tb/tb_draw_ball.sv - randomized self-checking bench for draw_ball against a frame-level model
module tb_draw_ball;

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic        hs;
    logic        vs;
    logic        hb;
    logic        vb;
    logic [11:0] rgb;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] hcount_in = '0, vcount_in = '0;
  logic        hsync_in = 1'b0, vsync_in = 1'b0, hblnk_in = 1'b0, vblnk_in = 1'b0;
  logic [11:0] rgb_in = '0;
  logic [10:0] xpos = '0, ypos = '0;
  logic [11:0] rom_addr;
  logic [3:0]  rom_pixel = '0;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;

  int checks = 0;
  int failures = 0;

  int   rom_mode = 0;
  int   xl = 0, yl = 0;
  bit   pvb = 1'b0;
  rec_t q[$];

  draw_ball dut (
    .clk(clk), .rst_n(rst_n),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .xpos(xpos), .ypos(ypos),
    .rom_addr(rom_addr), .rom_pixel(rom_pixel),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out),
    .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] rom_fn(input logic [11:0] a);
    case (rom_mode)
      1:       return (a == 12'h041) ? 4'h0 : 4'h5;
      2:       return a[3:0] ^ a[7:4] ^ a[11:8];
      default: return 4'h5;
    endcase
  endfunction

  // Registered sprite ROM: data follows the address by one clock.
  always @(posedge clk) rom_pixel <= rom_fn(rom_addr);

  function automatic logic [11:0] pal(input logic [3:0] i);
    logic [11:0] t [16];
    t = '{12'h000, 12'hFFF, 12'hF00, 12'h0F0, 12'h00F, 12'hFF0, 12'hF0F, 12'h0FF,
          12'h888, 12'hCCC, 12'h840, 12'hF80, 12'h08F, 12'h4A4, 12'hA4A, 12'h222};
    return t[i];
  endfunction

  task automatic model_reset();
    q.delete();
    q.push_back('0);
    q.push_back('0);
    xl = 0;
    yl = 0;
    pvb = 1'b0;
  endtask

  // One pixel clock: predict, clock, then compare rom_addr now and the output three clocks on.
  task automatic step();
    rec_t        e, exp_r, got;
    int          dx, dy;
    bit          inb, bl;
    logic [11:0] addr;
    logic [3:0]  px;
    e   = '{h: hcount_in, v: vcount_in, hs: hsync_in, vs: vsync_in,
            hb: hblnk_in, vb: vblnk_in, rgb: rgb_in};
    dx  = int'(hcount_in) - xl;
    dy  = int'(vcount_in) - yl;
    inb = (dx >= 0) && (dx < 64) && (dy >= 0) && (dy < 64);
    bl  = hblnk_in || vblnk_in;
    addr = inb ? 12'(dy * 64 + dx) : 12'h000;
    px  = rom_fn(addr);
    if (inb && !bl && px != 4'h0) e.rgb = pal(px);
`ifdef DRAW_BALL_BBOX_EN
    if (inb && !bl && (dx == 0 || dx == 63 || dy == 0 || dy == 63)) e.rgb = 12'hF00;
`endif
    q.push_back(e);
    if (vblnk_in && !pvb) begin
      xl = int'(xpos);
      yl = int'(ypos);
    end
    pvb = vblnk_in;
    @(posedge clk);
    #1;
    checks++;
    if (rom_addr !== addr) begin
      failures++;
      $display("FAIL rom_addr h=%0d v=%0d got=%h exp=%h", e.h, e.v, rom_addr, addr);
    end
    if (q.size() == 3) begin
      exp_r = q.pop_front();
      got = '{h: hcount_out, v: vcount_out, hs: hsync_out, vs: vsync_out,
              hb: hblnk_out, vb: vblnk_out, rgb: rgb_out};
      checks++;
      if (got !== exp_r) begin
        failures++;
        $display("FAIL stream h=%0d v=%0d got=%h exp=%h (rgb got=%h exp=%h)",
                 exp_r.h, exp_r.v, got, exp_r, got.rgb, exp_r.rgb);
      end
    end
  endtask

  task automatic rand_sigs();
    hsync_in = 1'($urandom);
    vsync_in = 1'($urandom);
    rgb_in   = 12'($urandom);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      rand_sigs();
      hblnk_in = 1'b1;
      vblnk_in = 1'b0;
      step();
    end
  endtask

  task automatic latch_pos(input int x, input int y);
    xpos = 11'(x);
    ypos = 11'(y);
    rand_sigs();
    hblnk_in = 1'b1;
    vblnk_in = 1'b1;
    step();
    step();
    vblnk_in = 1'b0;
    step();
  endtask

  task automatic scan_row(input int v, input int h0, input int h1);
    for (int h = h0; h <= h1; h++) begin
      rand_sigs();
      hcount_in = 11'(h);
      vcount_in = 11'(v);
      hblnk_in  = 1'b0;
      vblnk_in  = 1'b0;
      step();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out, rom_addr} !== '0) begin
      failures++;
      $display("FAIL reset_state got=%h exp=0",
               {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out, rom_addr});
    end
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 20; i++) begin
      rand_sigs();
      hcount_in = 11'($urandom_range(0, 799));
      vcount_in = 11'($urandom_range(0, 524));
      hblnk_in  = 1'($urandom);
      vblnk_in  = 1'b0;
      step();
    end
    // Assert reset between clock edges with live data in the pipe.
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out, rom_addr} !== '0) begin
      failures++;
      $display("FAIL async_reset got=%h exp=0",
               {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out, rom_addr});
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 10; i++) begin
      rand_sigs();
      hcount_in = 11'($urandom_range(0, 799));
      vcount_in = 11'($urandom_range(0, 524));
      step();
    end
  endtask

  task automatic test_passthrough();
    idle(4);
    rom_mode = 0;
    latch_pos(1000, 700);
    for (int i = 0; i < 200; i++) begin
      rand_sigs();
      hcount_in = 11'($urandom_range(0, 1023));
      vcount_in = 11'($urandom_range(0, 600));
      hblnk_in  = ($urandom_range(0, 7) == 0);
      vblnk_in  = 1'b0;
      step();
    end
  endtask

  task automatic test_corners();
    idle(4);
    rom_mode = 2;
    latch_pos(100, 200);
    scan_row(200, 100, 100);
    checks++;
    if (rom_addr !== 12'h000) begin
      failures++;
      $display("FAIL corner_tl got=%h exp=000", rom_addr);
    end
    scan_row(263, 163, 163);
    checks++;
    if (rom_addr !== 12'hFFF) begin
      failures++;
      $display("FAIL corner_br got=%h exp=FFF", rom_addr);
    end
    scan_row(263, 164, 164);
    checks++;
    if (rom_addr !== 12'h000) begin
      failures++;
      $display("FAIL past_right got=%h exp=000", rom_addr);
    end
    scan_row(199, 95, 170);
    scan_row(264, 95, 170);
    scan_row(230, 95, 170);
    idle(3);
  endtask

  task automatic test_transparent();
    idle(4);
    rom_mode = 1;
    for (int v = 199; v <= 203; v++) scan_row(v, 99, 103);
    idle(3);
  endtask

  task automatic test_midframe_move();
    idle(4);
    rom_mode = 2;
    latch_pos(100, 200);
    xpos = 11'd300;
    scan_row(210, 95, 370);
    latch_pos(300, 200);
    scan_row(210, 95, 370);
    idle(3);
  endtask

  task automatic test_right_edge();
    idle(4);
    rom_mode = 2;
    latch_pos(1000, 100);
    scan_row(100, 990, 1023);
    scan_row(100, 0, 45);
    scan_row(110, 995, 1023);
    scan_row(110, 0, 40);
    idle(3);
  endtask

  task automatic test_back_to_back();
    int x, y;
    idle(4);
    rom_mode = 2;
    for (int f = 0; f < 6; f++) begin
      x = $urandom_range(0, 1023);
      y = $urandom_range(0, 500);
      latch_pos(x, y);
      for (int i = 0; i < 120; i++) begin
        rand_sigs();
        hcount_in = 11'((x + $urandom_range(0, 80) - 8) & 11'h3FF);
        vcount_in = 11'((y + $urandom_range(0, 80) - 8) & 11'h3FF);
        hblnk_in  = ($urandom_range(0, 7) == 0);
        vblnk_in  = ($urandom_range(0, 31) == 0);
        xpos      = 11'($urandom_range(0, 1023));
        ypos      = 11'($urandom_range(0, 500));
        step();
      end
    end
    idle(3);
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_corners();
    test_transparent();
    test_midframe_move();
    test_right_edge();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
